// File: rtl/stack_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : stack_seq_if
// Purpose  : Request, result and byte-wide memory bus of the stack sequencer.
//            Carries the wrap flag only when STACK_SEQ_WRAP_DETECT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface stack_seq_if;
    logic        push;
    logic        pop;
    logic [15:0] push_data;
    logic        sp_load;
    logic [15:0] sp_load_val;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic        mem_wr;
    logic        mem_rd;
    logic [7:0]  mem_wdata;
    logic [15:0] pop_data;
    logic [15:0] sp;
    logic        busy;
    logic        done;
`ifdef STACK_SEQ_WRAP_DETECT_EN
    logic        wrap;
`endif

    modport slave (
        input  push, pop, push_data, sp_load, sp_load_val, mem_rdata,
        output mem_addr, mem_wr, mem_rd, mem_wdata, pop_data, sp, busy, done
`ifdef STACK_SEQ_WRAP_DETECT_EN
        , output wrap
`endif
    );

    modport master (
        output push, pop, push_data, sp_load, sp_load_val, mem_rdata,
        input  mem_addr, mem_wr, mem_rd, mem_wdata, pop_data, sp, busy, done
`ifdef STACK_SEQ_WRAP_DETECT_EN
        , input wrap
`endif
    );
endinterface
`default_nettype wire

// File: rtl/stack_seq.sv
`default_nettype none
// ============================================================================
// Module   : stack_seq
// Purpose  : Pushes/pops 16-bit words as two bytes over an 8-bit memory bus
//            with a descending stack pointer. Optional sticky SP wrap flag
//            enabled by defining STACK_SEQ_WRAP_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stack_seq #(
    parameter logic [15:0] SP_RESET = 16'hFFFE
) (
    input  logic       clock,
    input  logic       reset,
    stack_seq_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH_HI = 3'd1,
        ST_PUSH_LO = 3'd2,
        ST_POP_LO  = 3'd3,
        ST_POP_HI  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_sp;
    logic [15:0] w_sp_next;
    logic [15:0] r_data;
    logic [15:0] w_data_next;
    logic [7:0]  r_lo_byte;
    logic [7:0]  w_lo_byte_next;
    logic [15:0] r_pop_data;
    logic [15:0] w_pop_data_next;
    logic        r_done;
    logic        w_done_next;
    logic [15:0] w_mem_addr;
    logic        w_mem_wr;
    logic        w_mem_rd;
    logic [7:0]  w_mem_wdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_sp_next       = r_sp;
        w_data_next     = r_data;
        w_lo_byte_next  = r_lo_byte;
        w_pop_data_next = r_pop_data;
        w_done_next     = 1'b0;
        w_mem_addr      = r_sp;
        w_mem_wr        = 1'b0;
        w_mem_rd        = 1'b0;
        w_mem_wdata     = 8'h00;
        case (r_state)
            ST_IDLE: begin
                // One request per edge: sp_load beats push beats pop
                if (bus.sp_load) begin
                    w_sp_next = bus.sp_load_val;
                end else if (bus.push) begin
                    w_data_next  = bus.push_data;
                    w_sp_next    = r_sp - 16'd1;
                    w_state_next = ST_PUSH_HI;
                end else if (bus.pop) begin
                    w_state_next = ST_POP_LO;
                end
            end
            ST_PUSH_HI: begin
                w_mem_wr     = 1'b1;
                w_mem_wdata  = r_data[15:8];
                w_sp_next    = r_sp - 16'd1;
                w_state_next = ST_PUSH_LO;
            end
            ST_PUSH_LO: begin
                w_mem_wr     = 1'b1;
                w_mem_wdata  = r_data[7:0];
                w_done_next  = 1'b1;
                w_state_next = ST_IDLE;
            end
            ST_POP_LO: begin
                w_mem_rd       = 1'b1;
                w_lo_byte_next = bus.mem_rdata;
                w_sp_next      = r_sp + 16'd1;
                w_state_next   = ST_POP_HI;
            end
            ST_POP_HI: begin
                w_mem_rd        = 1'b1;
                w_pop_data_next = {bus.mem_rdata, r_lo_byte};
                w_sp_next       = r_sp + 16'd1;
                w_done_next     = 1'b1;
                w_state_next    = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sp       <= SP_RESET;
            r_data     <= 16'h0000;
            r_lo_byte  <= 8'h00;
            r_pop_data <= 16'h0000;
            r_done     <= 1'b0;
        end else begin
            r_sp       <= w_sp_next;
            r_data     <= w_data_next;
            r_lo_byte  <= w_lo_byte_next;
            r_pop_data <= w_pop_data_next;
            r_done     <= w_done_next;
        end
    end

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.pop_data  = r_pop_data;
    assign bus.sp        = r_sp;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;

`ifdef STACK_SEQ_WRAP_DETECT_EN
    logic r_wrap;
    logic w_wrap_set;
    logic w_wrap_clr;

    // Decrements happen on push acceptance and in PUSH_HI; increments in both pop states
    always_comb begin
        w_wrap_clr = (r_state == ST_IDLE) && bus.sp_load;
        w_wrap_set = 1'b0;
        if (r_sp == 16'h0000) begin
            w_wrap_set = (r_state == ST_PUSH_HI) ||
                         ((r_state == ST_IDLE) && !bus.sp_load && bus.push);
        end else if (r_sp == 16'hFFFF) begin
            w_wrap_set = (r_state == ST_POP_LO) || (r_state == ST_POP_HI);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else if (w_wrap_clr) begin
            r_wrap <= 1'b0;
        end else if (w_wrap_set) begin
            r_wrap <= 1'b1;
        end
    end

    assign bus.wrap = r_wrap;
`endif

endmodule
`default_nettype wire

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 SHALL have parameter SP_RESET, default 16'hFFFE, the SP value after reset.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port push  input  1  request to push push_data; sampled only in IDLE.
REQ-005 SHALL have port pop  input  1  request to pop into pop_data; sampled only in IDLE.
REQ-006 SHALL have port push_data  input  16  word to push; latched when a push is accepted.
REQ-007 SHALL have port sp_load  input  1  load SP from sp_load_val; sampled only in IDLE.
REQ-008 SHALL have port sp_load_val  input  16  new SP value.
REQ-009 SHALL have port mem_rdata  input  8  memory read data, valid in the same cycle as mem_rd.
REQ-010 SHALL have port mem_addr  output  16  memory address.
REQ-011 SHALL have port mem_wr  output  1  memory write strobe.
REQ-012 SHALL have port mem_rd  output  1  memory read strobe.
REQ-013 SHALL have port mem_wdata  output  8  memory write data.
REQ-014 SHALL have port pop_data  output  16  last popped word, registered.
REQ-015 SHALL have port sp  output  16  current stack pointer, registered.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse after a push or pop completes.

Function
REQ-018 SHALL implement the states IDLE, PUSH_HI, PUSH_LO, POP_LO and POP_HI.
REQ-019 SHALL give request priority in IDLE as sp_load > push > pop; only one request is accepted per edge.
REQ-020 SHALL ignore push, pop and sp_load while busy is high, with no queuing.
REQ-021 SHALL handle an sp_load accepted in IDLE as follows: sp<=sp_load_val, stay in IDLE, no memory access, no done pulse.
REQ-022 SHALL handle a push accepted in IDLE as follows: latch push_data, sp<=sp-1, go to PUSH_HI.
REQ-023 SHALL drive, in PUSH_HI: mem_addr=sp, mem_wr=1, mem_wdata=data[15:8]; on the edge, sp<=sp-1 and go to PUSH_LO.
REQ-024 SHALL drive, in PUSH_LO: mem_addr=sp, mem_wr=1, mem_wdata=data[7:0]; on the edge, go to IDLE and set done=1 for the next cycle.
REQ-025 SHALL handle a pop accepted in IDLE as follows: go to POP_LO, sp unchanged.
REQ-026 SHALL drive, in POP_LO: mem_addr=sp, mem_rd=1; on the edge, capture mem_rdata as the low byte, sp<=sp+1, go to POP_HI.
REQ-027 SHALL drive, in POP_HI: mem_addr=sp, mem_rd=1; on the edge, capture the high byte, update pop_data with the full word, sp<=sp+1, go to IDLE, set done=1.
REQ-028 SHALL drive, in IDLE: mem_addr=sp, mem_wr=0, mem_rd=0, mem_wdata=8'h00.
REQ-029 SHALL perform all SP arithmetic modulo 2^16 (0x0000-1=0xFFFF, 0xFFFF+1=0x0000).
REQ-030 SHALL give a push latency of 3 edges and a pop latency of 3 edges from acceptance to done.
REQ-031 SHALL allow a new request in the same cycle that done is high; done SHALL NOT persist beyond one cycle.
REQ-032 SHALL leave pop_data unchanged by push and by any incomplete pop.

Reset
REQ-033 SHALL, while reset is high, immediately force: state=IDLE, sp=SP_RESET, pop_data=16'h0000, done=0, busy=0, and mem_wr/mem_rd=0.
REQ-034 SHALL abort any operation in progress when reset asserts mid-operation; the partial SP change and the partial pop byte are discarded.

Configuration
REQ-035 SHALL, when macro STACK_SEQ_WRAP_DETECT_EN is defined, add output port wrap (1 bit): a sticky flag set when any SP decrement passes 0x0000 to 0xFFFF or any increment passes 0xFFFF to 0x0000, cleared by reset or an accepted sp_load.
REQ-036 SHALL, without STACK_SEQ_WRAP_DETECT_EN, omit the wrap port and all of its logic, with all other behaviour identical.

Verification
REQ-037 SHALL cover this scenario: reset; push 16'hABCD -> writes 0xFFFD=AB, then 0xFFFC=CD on consecutive cycles; sp=0xFFFC; done pulses once.
REQ-038 SHALL cover this scenario: after REQ-037, pop with memory returning CD then AB -> reads 0xFFFC, then 0xFFFD; pop_data=0xABCD; sp=0xFFFE.
REQ-039 SHALL cover this scenario: sp_load 0x0001, push 0x1234 -> writes 0x0000=12, then 0xFFFF=34; sp=0xFFFF; wrap=1 (macro defined).
REQ-040 SHALL cover this scenario: push and pop asserted together in IDLE -> push executes; pop ignored; push asserted during PUSH_HI -> ignored.
REQ-041 SHALL cover this scenario: reset asserted during POP_HI -> outputs go immediately to reset values; pop_data=0x0000; sp=0xFFFE.
REQ-042 SHALL cover this scenario: sp_load 0xFFFF, pop -> reads 0xFFFF, then 0x0000; sp=0x0001; wrap=1 (macro defined).
